fft_frame_loader: RTL

Upstream loader for the iterative FFT core (`top_fft_iter`). It accepts a stream of complex samples through a valid/ready handshake and packs consecutive sample pairs into one dual-port RAM write (ports A and B), with bit-reversed addresses. After the last pair of a 2^AWL-point frame it pulses the FFT start strobe. It then holds off new input while the core reports its RAM blocked.

---
 rtl/fft_frame_loader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fft_frame_loader.sv
// -----------------------------------------------------------------------------
// fft_frame_loader
//
// Upstream loader for the iterative FFT core. Accepts complex samples over a
// valid/ready handshake, pairs each even-index sample with the following
// odd-index sample and issues one dual-port RAM write (ports A and B) per
// pair. After the last pair of a 2^AWL-point frame it pulses o_START, then
// holds off new input until the core has claimed (i_RAM_BLOCK high) and
// released (i_RAM_BLOCK low) its RAM.
//
// Build option:
//   FFT_LOADER_BITREV_EN  defined   -> A/B addresses are bit-reversed k-1 / k
//                         undefined -> natural order k-1 / k
//
// Parameters:
//   IWL  sample width (re in upper half, im in lower half, passed through)
//   AWL  address width, frame length N = 2^AWL (AWL >= 2)
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   i_EN              global enable; low freezes everything, o_READY = 0
//   i_VALID, i_DATA   input sample stream
//   o_READY           sample accepted this cycle when i_VALID is also high
//   o_A_DATA/o_B_DATA even/odd sample of the pair
//   o_A_ADDR/o_B_ADDR RAM addresses for ports A/B
//   o_RAM_Wr          one-cycle write strobe for both ports
//   o_START           one-cycle FFT start pulse
//   i_RAM_BLOCK       FFT core owns the RAM
//   o_BUSY            frame loaded, waiting for the FFT to finish
// -----------------------------------------------------------------------------
module fft_frame_loader #(
    parameter int IWL = 32,
    parameter int AWL = 11
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           i_EN,
    input  logic           i_VALID,
    input  logic [IWL-1:0] i_DATA,
    output logic           o_READY,
    output logic [IWL-1:0] o_A_DATA,
    output logic [IWL-1:0] o_B_DATA,
    output logic [AWL-1:0] o_A_ADDR,
    output logic [AWL-1:0] o_B_ADDR,
    output logic           o_RAM_Wr,
    output logic           o_START,
    input  logic           i_RAM_BLOCK,
    output logic           o_BUSY
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_ACK   = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_live;
    logic [AWL-1:0] r_k;
    logic [IWL-1:0] r_hold;
    logic [IWL-1:0] r_a_data;
    logic [IWL-1:0] r_b_data;
    logic [AWL-1:0] r_a_addr;
    logic [AWL-1:0] r_b_addr;
    logic           r_wr;
    logic           r_start;
    logic           r_busy;

    logic           w_ready;
    logic           w_accept;
    logic           w_start_set;
    logic           w_last;
    logic [AWL-1:0] w_k_even;
    logic [AWL-1:0] w_addr_a;
    logic [AWL-1:0] w_addr_b;

    assign w_last   = (r_k == '1);
    assign w_k_even = {r_k[AWL-1:1], 1'b0};

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------
`ifdef FFT_LOADER_BITREV_EN
    always_comb begin
        w_addr_a = '0;
        w_addr_b = '0;
        for (int unsigned i = 0; i < AWL; i++) begin
            w_addr_a[i] = w_k_even[AWL-1-i];
            w_addr_b[i] = r_k[AWL-1-i];
        end
    end
`else
    assign w_addr_a = w_k_even;
    assign w_addr_b = r_k;
`endif

    // ------------------------------------------------------------------
    // Out-of-reset flag: keeps o_READY low while reset is asserted even
    // though the state decodes as FILL. Not gated by i_EN so the loader is
    // ready on the very first enabled cycle after reset release.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_FILL;
        end else if (i_EN) begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and decoded controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_accept    = 1'b0;
        w_start_set = 1'b0;
        case (r_state)
            S_FILL: begin
                w_ready  = r_live & i_EN & ~i_RAM_BLOCK;
                w_accept = i_VALID & w_ready;
                if (w_accept && w_last) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_start_set = 1'b1;
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                if (i_RAM_BLOCK) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_RAM_BLOCK) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: sample counter, hold register, write pair, strobes
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_k      <= '0;
            r_hold   <= '0;
            r_a_data <= '0;
            r_b_data <= '0;
            r_a_addr <= '0;
            r_b_addr <= '0;
            r_wr     <= 1'b0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
        end else if (i_EN) begin
            if (w_accept) begin
                r_k <= r_k + 1'b1;
                if (!r_k[0]) begin
                    r_hold <= i_DATA;
                end else begin
                    r_a_data <= r_hold;
                    r_b_data <= i_DATA;
                    r_a_addr <= w_addr_a;
                    r_b_addr <= w_addr_b;
                end
            end
            r_wr    <= w_accept & r_k[0];
            r_start <= w_start_set;
            r_busy  <= (w_state_nxt != S_FILL);
        end
    end

    // Strobes stay set in their registers while disabled (registers hold),
    // so masking with i_EN delays them to the first enabled cycle rather
    // than dropping them.
    assign o_READY  = w_ready;
    assign o_RAM_Wr = r_wr & i_EN;
    assign o_START  = r_start & i_EN;
    assign o_A_DATA = r_a_data;
    assign o_B_DATA = r_b_data;
    assign o_A_ADDR = r_a_addr;
    assign o_B_ADDR = r_b_addr;
    assign o_BUSY   = r_busy;

endmodule
